shift_reg_univ: RTL and testbench
=================================

Name: shift_reg_univ

Overview:
Parametrised universal shift register, the successor to the fixed serial-in/serial-out shifter.
Supports hold, shift-right, shift-left and parallel-load modes, with serial and parallel in/out.
A frame counter flags every WIDTH shifts.
Used as the serial/parallel converter for bit-serial links and as a configurable delay line.

Parameters:
WIDTH, 8, register length in bits (legal range WIDTH >= 2)
CNT_W, $clog2(WIDTH+1), width of the shift counter (derived; do not override)

Ports:
clk    input   1         rising-edge clock
rst    input   1         synchronous reset, active-high
en     input   1         operation enable; when 0 all state holds
mode   input   2         00 hold, 01 shift right, 10 shift left, 11 parallel load
si     input   1         serial input bit
pdin   input   WIDTH     parallel load data
so     output  1         serial output
pdout  output  WIDTH     register contents q
cnt    output  CNT_W     shifts since last load/reset/frame wrap
done   output  1         one-cycle frame-complete pulse

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset priority: rst overrides en and mode.
- Values after a reset edge: q=0, dir_r=0 (right), cnt=0, done=0. Hence pdout=0 and so=0.
- State registers: q[WIDTH-1:0], dir_r (last shift direction), cnt, done.
- en=0: q, dir_r and cnt hold; done <= 0.
- en=1, mode=00 (hold): q, dir_r and cnt hold; done <= 0.
- en=1, mode=01 (shift right):
  - q <= {si, q[WIDTH-1:1]}, dir_r <= 0.
  - The bit leaving q[0] is discarded.
- en=1, mode=10 (shift left):
  - q <= {q[WIDTH-2:0], si}, dir_r <= 1.
  - The bit leaving q[WIDTH-1] is discarded.
- en=1, mode=11 (load):
  - q <= pdin, cnt <= 0, done <= 0.
  - dir_r is unchanged.
- so is combinational from registers only, never from inputs: so = dir_r ? q[WIDTH-1] : q[0].
- SISO latency: a bit presented on si during a shift cycle appears on so after exactly WIDTH shift edges in the same direction. Non-shift cycles interleaved with en=0 or mode=00 do not count.
- Counter, on every shift (mode 01 or 10 with en=1):
  - If cnt == WIDTH-1: cnt <= 0, done <= 1.
  - Otherwise: cnt <= cnt+1, done <= 0.
- done pulse: high for exactly one cycle, coincident with pdout holding the full WIDTH-bit frame. On back-to-back frames it pulses once per WIDTH shifts with no gap cycle.
- Direction change mid-frame: allowed. cnt keeps counting shifts regardless of direction; so follows the new dir_r from the next cycle.
- Load mid-frame: aborts the frame; the count restarts from 0.
- Reset mid-frame: aborts the frame; no done pulse is generated.
- Simultaneous load and shift are impossible by encoding. No other illegal inputs exist; all 4 mode codes are defined.
- No combinational path from any input to any output.

Test Plan:
1. Reset priority: rst=1, en=1, mode=11, pdin=8'hFF for 2 cycles -> after each edge pdout=8'h00, so=0, cnt=0, done=0.
2. SISO right (WIDTH=8):
   - Stimulus: after reset, en=1, mode=01, si = 1,0,1,1,0,0,1,0 on 8 consecutive edges.
   - Expected: after the 8th edge pdout=8'h4D, so=1, cnt=0, done=1 for that single cycle; done=0 on the next cycle with mode=00.
3. Load then shift left:
   - Stimulus: mode=11, pdin=8'hA5, then 4 edges of mode=10 with si=1.
   - Expected pdout: 8'h4B, 8'h97, 8'h2F, 8'h5F.
   - Expected so: 0, 1, 0, 0.
   - Expected finally: cnt=4, done never asserted.
4. Enable/hold gating:
   - Stimulus: 3 right shifts, then en=0 for 3 cycles, then en=1 with mode=00 for 2 cycles, then 5 more right shifts.
   - Expected: pdout and cnt frozen during the 5 idle cycles; done pulses only after the 8th actual shift.
5. Reset mid-frame:
   - Stimulus: 5 right shifts with si=1, then rst=1 for one edge, then 8 right shifts with si=1.
   - Expected: all state zero after the reset edge; no done pulse before the reset; done pulses only after the 8th post-reset shift; pdout=8'hFF.
6. Continuous frames: 16 uninterrupted right shifts -> done high exactly after shift 8 and shift 16, cnt sequence 1..7,0,1..7,0.

Source files
------------

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold, shift right, shift left and parallel load,
// with serial/parallel in/out and a frame counter that pulses done every WIDTH shifts.
module shift_reg_univ #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             si,
   input  logic [WIDTH-1:0] pdin,
   output logic             so,
   output logic [WIDTH-1:0] pdout,
   output logic [CNT_W-1:0] cnt,
   output logic             done
);

   typedef enum logic [1:0] {
      MODE_HOLD  = 2'b00,
      MODE_RIGHT = 2'b01,
      MODE_LEFT  = 2'b10,
      MODE_LOAD  = 2'b11
   } mode_t;

   mode_t            op;
   logic [WIDTH-1:0] q;
   logic             dir_r;
   logic             frame_end;

   assign op        = mode_t'(mode);
   assign frame_end = (cnt == CNT_W'(WIDTH - 1));

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values of the others, regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         q     <= '0;
         dir_r <= 1'b0;
         cnt   <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (en) begin
            unique case (op)
               MODE_HOLD: ;
               MODE_RIGHT, MODE_LEFT: begin
                  if (op == MODE_RIGHT) begin
                     q     <= {si, q[WIDTH-1:1]};
                     dir_r <= 1'b0;
                  end else begin
                     q     <= {q[WIDTH-2:0], si};
                     dir_r <= 1'b1;
                  end
                  // Count shifts in either direction; wrap and flag at a full frame.
                  if (frame_end) begin
                     cnt  <= '0;
                     done <= 1'b1;
                  end else begin
                     cnt  <= cnt + 1'b1;
                  end
               end
               MODE_LOAD: begin
                  q   <= pdin;
                  cnt <= '0;
               end
               default: ;
            endcase
         end
      end
   end

   // Serial output comes from the end the last shift was moving towards.
   assign so    = dir_r ? q[WIDTH-1] : q[0];
   assign pdout = q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ: directed plan steps plus a randomized
// run, all compared against an arithmetic reference model of the register.
module tb_shift_reg_univ;

   localparam int W  = 8;
   localparam int CW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          en = 1'b0;
   logic [1:0]    mode = 2'b00;
   logic          si = 1'b0;
   logic [W-1:0]  pdin = '0;
   logic          so;
   logic [W-1:0]  pdout;
   logic [CW-1:0] cnt;
   logic          done;

   int n_total = 0;
   int n_pass  = 0;

   // Reference model state: register value, last direction, shifts since load/reset.
   int unsigned m_q;
   bit          m_dir;
   int          m_shifts;
   bit          m_done;

   shift_reg_univ #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .mode  (mode),
      .si    (si),
      .pdin  (pdin),
      .so    (so),
      .pdout (pdout),
      .cnt   (cnt),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_update(input bit r, input bit e, input bit [1:0] m,
                               input bit s, input bit [W-1:0] p);
      int unsigned mask;
      mask = (1 << W) - 1;
      if (r) begin
         m_q = 0; m_dir = 0; m_shifts = 0; m_done = 0;
      end else if (!e || m == 2'b00) begin
         m_done = 0;
      end else if (m == 2'b11) begin
         m_q = p; m_shifts = 0; m_done = 0;
      end else begin
         if (m == 2'b01) begin
            m_q   = (m_q / 2) + (s ? (1 << (W - 1)) : 0);
            m_dir = 0;
         end else begin
            m_q   = ((m_q * 2) + s) & mask;
            m_dir = 1;
         end
         m_shifts++;
         m_done = (m_shifts % W) == 0;
      end
   endtask

   task automatic check_model(input string tag);
      bit exp_so;
      exp_so = m_dir ? m_q[W-1] : m_q[0];
      check({tag, ".pdout"}, 32'(pdout), m_q);
      check({tag, ".so"},    32'(so),    32'(exp_so));
      check({tag, ".cnt"},   32'(cnt),   32'(m_shifts % W));
      check({tag, ".done"},  32'(done),  32'(m_done));
   endtask

   // One clock: drive inputs, take the edge, advance the model, sample 1 time unit later.
   task automatic step(input string tag, input logic r, input logic e, input logic [1:0] m,
                       input logic s, input logic [W-1:0] p);
      rst = r; en = e; mode = m; si = s; pdin = p;
      @(posedge clk);
      model_update(r, e, m, s, p);
      #1;
      check_model(tag);
   endtask

   initial begin
      logic [7:0] bits2;
      logic [7:0] exp_q3 [4];
      logic       exp_so3 [4];
      m_q = 0; m_dir = 0; m_shifts = 0; m_done = 0;

      // 1. Reset overrides a load request.
      for (int i = 0; i < 2; i++) begin
         step("rst_prio", 1'b1, 1'b1, 2'b11, 1'b0, 8'hFF);
         check("rst_prio.pdout_const", 32'(pdout), 32'h00);
      end

      // 2. Serial-in right shift; first bit lands at q[0] after 8 edges.
      bits2 = 8'b0100_1101;
      for (int i = 0; i < 8; i++) begin
         step("siso_r", 1'b0, 1'b1, 2'b01, bits2[i], '0);
         if (i < 7) check("siso_r.no_done", 32'(done), 32'h0);
      end
      check("siso_r.pdout_const", 32'(pdout), 32'h4D);
      check("siso_r.so_const",    32'(so),    32'h1);
      check("siso_r.cnt_const",   32'(cnt),   32'h0);
      check("siso_r.done_const",  32'(done),  32'h1);
      step("siso_r_hold", 1'b0, 1'b1, 2'b00, 1'b0, '0);
      check("siso_r_hold.done_const", 32'(done), 32'h0);

      // 3. Load then shift left with si=1.
      exp_q3  = '{8'h4B, 8'h97, 8'h2F, 8'h5F};
      exp_so3 = '{1'b0, 1'b1, 1'b0, 1'b0};
      step("load", 1'b0, 1'b1, 2'b11, 1'b0, 8'hA5);
      check("load.pdout_const", 32'(pdout), 32'hA5);
      for (int i = 0; i < 4; i++) begin
         step("shl", 1'b0, 1'b1, 2'b10, 1'b1, '0);
         check("shl.pdout_const", 32'(pdout), 32'(exp_q3[i]));
         check("shl.so_const",    32'(so),    32'(exp_so3[i]));
         check("shl.no_done",     32'(done),  32'h0);
      end
      check("shl.cnt_const", 32'(cnt), 32'h4);

      // 4. Enable and hold gating do not advance the frame.
      step("gate_rst", 1'b1, 1'b0, 2'b00, 1'b0, '0);
      for (int i = 0; i < 3; i++) step("gate_sh", 1'b0, 1'b1, 2'b01, i[0], '0);
      for (int i = 0; i < 3; i++) step("gate_en0", 1'b0, 1'b0, 2'b01, 1'b1, 8'hFF);
      for (int i = 0; i < 2; i++) step("gate_hold", 1'b0, 1'b1, 2'b00, 1'b1, 8'hFF);
      check("gate.cnt_frozen", 32'(cnt), 32'h3);
      for (int i = 0; i < 5; i++) begin
         step("gate_sh2", 1'b0, 1'b1, 2'b01, 1'b1, '0);
         check("gate.done_const", 32'(done), (i == 4) ? 32'h1 : 32'h0);
      end

      // 5. Reset mid-frame aborts it.
      step("mid_rst0", 1'b1, 1'b0, 2'b00, 1'b0, '0);
      for (int i = 0; i < 5; i++) step("mid_sh", 1'b0, 1'b1, 2'b01, 1'b1, '0);
      step("mid_rst", 1'b1, 1'b1, 2'b01, 1'b1, '0);
      check("mid_rst.pdout_const", 32'(pdout), 32'h0);
      check("mid_rst.cnt_const",   32'(cnt),   32'h0);
      for (int i = 0; i < 8; i++) begin
         step("mid_sh2", 1'b0, 1'b1, 2'b01, 1'b1, '0);
         check("mid_sh2.done_const", 32'(done), (i == 7) ? 32'h1 : 32'h0);
      end
      check("mid_sh2.pdout_const", 32'(pdout), 32'hFF);

      // 6. Back-to-back frames with no gap.
      step("cont_rst", 1'b1, 1'b0, 2'b00, 1'b0, '0);
      for (int i = 1; i <= 16; i++) begin
         step("cont", 1'b0, 1'b1, 2'b01, 1'($urandom_range(0, 1)), '0);
         check("cont.cnt_const",  32'(cnt),  32'(i % 8));
         check("cont.done_const", 32'(done), (i % 8 == 0) ? 32'h1 : 32'h0);
      end

      // Randomized traffic, including direction changes, loads and rare resets.
      for (int i = 0; i < 400; i++) begin
         step("rand",
              1'($urandom_range(0, 31) == 0),
              1'($urandom_range(0, 3) != 0),
              2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)),
              8'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
